// File: rtl/oam_dma_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | oam_dma_ctrl_pkg : shared DMA state type, register address, mirroring  |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package oam_dma_ctrl_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    // Pages E0-FF alias the WRAM pages C0-DF.
    function automatic logic [7:0] dma_mirror_page(input logic [7:0] i_val);
        return (i_val < 8'hE0) ? i_val : (i_val & 8'hDF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | oam_dma_ctrl : copies NUM_BYTES bytes from page {val,00} into OAM      |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_BYTE   = 4,
    parameter int NUM_BYTES         = 160,
    parameter int START_DELAY_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_reg_write,
    input  logic [7:0]  i_reg_d_wr,
    output logic [7:0]  o_reg_d_rd,
    output logic [15:0] o_bus_addr,
    input  logic [7:0]  i_bus_d_in,
    output logic        o_dma_active,
    input  logic        i_oam_grant,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_d_wr,
    output logic        o_oam_write
);

    localparam int             c_CW          = $clog2(CYCLES_PER_BYTE);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]     c_IDX_LAST    = 8'(NUM_BYTES - 1);
    localparam logic [7:0]     c_START_LAST  = 8'(START_DELAY_SLOTS - 1);

    dma_state_t      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [7:0]      r_index;
    logic [7:0]      r_page;
    logic [7:0]      r_reg_d_rd;
    logic [15:0]     r_bus_addr;
    logic            r_dma_active;
    logic [7:0]      r_oam_addr;
    logic [7:0]      r_oam_d_wr;
    logic            r_oam_write;

    logic [7:0]      w_new_page;

    assign w_new_page = dma_mirror_page(i_reg_d_wr);

    // During START the index register counts elapsed delay slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= DMA_IDLE;
            r_cnt        <= '0;
            r_index      <= 8'h00;
            r_page       <= 8'h00;
            r_reg_d_rd   <= 8'h00;
            r_bus_addr   <= 16'h0000;
            r_dma_active <= 1'b0;
            r_oam_addr   <= 8'h00;
            r_oam_d_wr   <= 8'h00;
            r_oam_write  <= 1'b0;
        end else begin
            r_oam_write <= 1'b0;
            if (i_reg_write) begin
                r_page       <= w_new_page;
                r_reg_d_rd   <= i_reg_d_wr;
                r_index      <= 8'h00;
                r_cnt        <= '0;
                r_dma_active <= 1'b1;
                if (START_DELAY_SLOTS == 0) begin
                    r_state    <= DMA_XFER;
                    r_bus_addr <= {w_new_page, 8'h00};
                end else begin
                    r_state    <= DMA_START;
                    r_bus_addr <= 16'h0000;
                end
            end else begin
                case (r_state)
                    DMA_IDLE: begin
                        r_dma_active <= 1'b0;
                        r_bus_addr   <= 16'h0000;
                    end
                    DMA_START: begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt <= '0;
                            if (r_index == c_START_LAST) begin
                                r_index    <= 8'h00;
                                r_state    <= DMA_XFER;
                                r_bus_addr <= {r_page, 8'h00};
                            end else begin
                                r_index <= r_index + 8'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DMA_XFER: begin
                        if (r_cnt != c_CNT_LAST) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (i_oam_grant) begin
                            r_oam_write <= 1'b1;
                            r_oam_addr  <= r_index;
                            r_oam_d_wr  <= i_bus_d_in;
                            r_cnt       <= '0;
                            if (r_index == c_IDX_LAST) begin
                                r_state      <= DMA_IDLE;
                                r_index      <= 8'h00;
                                r_dma_active <= 1'b0;
                                r_bus_addr   <= 16'h0000;
                            end else begin
                                r_index    <= r_index + 8'd1;
                                r_bus_addr <= {r_page, r_index + 8'd1};
                            end
                        end
                    end
                    default: begin
                        r_state      <= DMA_IDLE;
                        r_dma_active <= 1'b0;
                        r_bus_addr   <= 16'h0000;
                    end
                endcase
            end
        end
    end

    assign o_reg_d_rd   = r_reg_d_rd;
    assign o_bus_addr   = r_bus_addr;
    assign o_dma_active = r_dma_active;
    assign o_oam_addr   = r_oam_addr;
    assign o_oam_d_wr   = r_oam_d_wr;
    assign o_oam_write  = r_oam_write;

endmodule
`default_nettype wire
